// File: rtl/input_reg.sv
// Input image register: synchronises and debounces field inputs, then freezes a
// snapshot (plus per-bit rising-edge flags) on scanLatch for bit-addressed reads.
module input_reg #(
  parameter int INPUT_NUMBER    = 8,
  parameter int INPUT_ADDR_LEN  = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [INPUT_NUMBER-1:0]   inputs,
  input  logic                      scanLatch,
  input  logic                      inputRd,
  input  logic [INPUT_ADDR_LEN-1:0] inputRdAddr,
  output logic                      inputReadOut,
  output logic                      inputEdgeOut,
  output logic                      inputReadValid
);

  localparam int         ADDR_SPAN = 1 << INPUT_ADDR_LEN;
  localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);

  logic [INPUT_NUMBER-1:0] r_sync1;
  logic [INPUT_NUMBER-1:0] r_sync2;
  logic [INPUT_NUMBER-1:0] r_deb;
  logic [INPUT_NUMBER-1:0] r_image;
  logic [INPUT_NUMBER-1:0] r_edge;
  logic [7:0]              r_cnt [INPUT_NUMBER];
  logic [ADDR_SPAN-1:0]    w_image_ext;
  logic [ADDR_SPAN-1:0]    w_edge_ext;

  // Two-flop synchroniser for the asynchronous field inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= inputs;
      r_sync2 <= r_sync1;
    end
  end

  // Per-channel debounce: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb <= '0;
      for (int i = 0; i < INPUT_NUMBER; i++) r_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < INPUT_NUMBER; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= 8'd0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= 8'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Snapshot; edge flags mark 0->1 changes relative to the previous snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_image <= '0;
      r_edge  <= '0;
    end else if (scanLatch) begin
      r_image <= r_deb;
      r_edge  <= r_deb & ~r_image;
    end else begin
      r_image <= r_image;
      r_edge  <= r_edge;
    end
  end

  // Zero-padded to the full address span so out-of-range reads return 0.
  always_comb begin
    w_image_ext                   = '0;
    w_edge_ext                    = '0;
    w_image_ext[INPUT_NUMBER-1:0] = r_image;
    w_edge_ext[INPUT_NUMBER-1:0]  = r_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inputReadOut   <= 1'b0;
      inputEdgeOut   <= 1'b0;
      inputReadValid <= 1'b0;
    end else if (inputRd) begin
      inputReadOut   <= w_image_ext[inputRdAddr];
      inputEdgeOut   <= w_edge_ext[inputRdAddr];
      inputReadValid <= 1'b1;
    end else begin
      inputReadValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_reg.sv
// Scoreboard bench for input_reg (6 inputs, 3-bit address, debounce of 4 cycles).
module tb_input_reg;

  localparam int N = 6;

  logic         clk;
  logic         reset;
  logic [N-1:0] inputs;
  logic         scanLatch;
  logic         inputRd;
  logic [2:0]   inputRdAddr;
  logic         inputReadOut;
  logic         inputEdgeOut;
  logic         inputReadValid;

  typedef struct {
    int   addr;
    logic rd;
    logic edg;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  input_reg #(
    .INPUT_NUMBER   (N),
    .INPUT_ADDR_LEN (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inputs        (inputs),
    .scanLatch     (scanLatch),
    .inputRd       (inputRd),
    .inputRdAddr   (inputRdAddr),
    .inputReadOut  (inputReadOut),
    .inputEdgeOut  (inputEdgeOut),
    .inputReadValid(inputReadValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input int a, input logic rd, input logic edg);
    exp_t e;
    e.addr = a; e.rd = rd; e.edg = edg;
    sb_q.push_back(e);
    inputRd     = 1'b1;
    inputRdAddr = 3'(a);
    cyc(1);
    inputRd     = 1'b0;
  endtask

  task automatic do_latch();
    scanLatch = 1'b1;
    cyc(1);
    scanLatch = 1'b0;
  endtask

  task automatic do_latch_read(input int a, input logic rd, input logic edg);
    scanLatch = 1'b1;
    do_read(a, rd, edg);
    scanLatch = 1'b0;
  endtask

  // Monitor: every valid read is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (inputReadValid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("read_addr%0d rd/edge", e.addr),
              {30'd0, inputReadOut, inputEdgeOut}, {30'd0, e.rd, e.edg});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    inputs      = 6'h3F;
    scanLatch   = 1'b0;
    inputRd     = 1'b0;
    inputRdAddr = 3'd0;

    // Reset with all inputs high: outputs clear, image stays empty.
    cyc(1);
    check("reset_outputs", {29'd0, inputReadValid, inputReadOut, inputEdgeOut}, 32'd0);
    cyc(1);
    reset  = 1'b0;
    inputs = 6'h00;
    for (int a = 0; a < 8; a++) do_read(a, 1'b0, 1'b0);

    // Debounce accept on bit 3: flip at E5, so a latch at E5 still sees 0.
    inputs = 6'b001000;
    cyc(5);
    do_latch();                       // E5
    do_latch_read(3, 1'b0, 1'b0);     // E6 latch + read of the E5 image
    do_read(3, 1'b1, 1'b1);           // E7

    // Glitch on bit 5 lasting 3 cycles is rejected; bit 3 edge clears.
    inputs = 6'b101000;
    cyc(3);
    inputs = 6'b001000;
    cyc(4);
    do_latch();
    do_read(5, 1'b0, 1'b0);
    do_read(3, 1'b1, 1'b0);
    do_latch();
    do_read(3, 1'b1, 1'b0);

    // Falling change on bit 3 sets no edge.
    inputs = 6'b000000;
    cyc(6);
    do_latch();
    do_read(3, 1'b0, 1'b0);

    // Simultaneous latch and read returns the pre-latch image.
    inputs = 6'b000001;
    cyc(6);
    do_latch_read(0, 1'b0, 1'b0);
    do_read(0, 1'b1, 1'b1);
    cyc(1);
    check("hold_after_read", {29'd0, inputReadValid, inputReadOut, inputEdgeOut}, 32'b011);

    // Out-of-range addresses.
    do_read(7, 1'b0, 1'b0);
    do_read(6, 1'b0, 1'b0);
    do_read(0, 1'b1, 1'b1);

    // Reset two cycles into a rise on bit 2; debounce restarts from scratch.
    inputs = 6'b000101;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check("midreset_outputs", {29'd0, inputReadValid, inputReadOut, inputEdgeOut}, 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(5);                           // F1..F5
    do_latch();                       // F6: deb flips here, latch sees 0
    do_latch_read(2, 1'b0, 1'b0);     // F7
    do_read(2, 1'b1, 1'b1);           // F8
    do_read(0, 1'b1, 1'b1);

    cyc(3);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_reg.md
# input_reg

Debounced, scan-latched input image register: the read-side counterpart of the output register. It synchronises `INPUT_NUMBER` asynchronous field inputs, debounces each one, and freezes a coherent snapshot (the input image) on a scan-latch pulse from the control unit. The processor reads single bits of the image by address, together with a per-bit rising-edge flag, for bit-oriented IL instructions (LD/AND/OR on inputs, R_TRIG-style tests).

## Interface
Parameters:
- `INPUT_NUMBER`, default 8: number of field inputs.
- `INPUT_ADDR_LEN`, default 3: address width; must satisfy 2^`INPUT_ADDR_LEN` ≥ `INPUT_NUMBER`.
- `DEBOUNCE_CYCLES`, default 4: consecutive disagreeing cycles needed to accept a change. Legal range 1..255.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inputs`  in  `INPUT_NUMBER`  asynchronous field inputs.
- `scanLatch`  in  1  one-cycle pulse; copies the debounced state into the image.
- `inputRd`  in  1  read request for one image bit.
- `inputRdAddr`  in  `INPUT_ADDR_LEN`  bit index to read.
- `inputReadOut`  out  1  image bit at the requested address.
- `inputEdgeOut`  out  1  rising-edge flag at the requested address.
- `inputReadValid`  out  1  high for one cycle when the two read outputs are valid.

## Operation
- **Synchroniser.** Two flops per input: `sync1 <= inputs`, `sync2 <= sync1`.
- **Debouncer.** Per channel: one debounced bit `deb[i]` and an 8-bit counter `cnt[i]`. Each edge:
  - If `sync2[i] == deb[i]`: `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`: `deb[i] <= sync2[i]` and `cnt[i] <= 0`.
  - Otherwise: `cnt[i] <= cnt[i]+1`.
  - A disagreement shorter than `DEBOUNCE_CYCLES` cycles is discarded. The counter restarts on any agreement.
- **Scan latch.** When `scanLatch` is 1: `image <= deb` and `edge <= deb & ~image`. `image` on the right-hand side is the pre-latch value. `edge` is thus set only for 0→1 changes since the previous latch and is recomputed on every latch. Between latches, `image` and `edge` hold.
- **Read.** When `inputRd` is 1 at edge E, the following hold from edge E until the next edge:
  - `inputReadOut = image[addr]` and `inputEdgeOut = edge[addr]`.
  - `inputReadValid = 1`.
  - Otherwise `inputReadValid = 0` and the read outputs hold their last values.
- **Out-of-range address** (`addr >= INPUT_NUMBER`): `inputReadOut = 0`, `inputEdgeOut = 0`, `inputReadValid = 1`.
- **Simultaneous `scanLatch` and `inputRd`:** the read returns the pre-latch `image` and `edge`. The new snapshot is visible to reads issued on the next cycle onward.
- **Back-to-back reads:** one per cycle, no stall.
- **Reset** (`reset = 1` at an edge) clears all of the following, and has priority over `scanLatch` and `inputRd`:
  - `sync1`, `sync2`, `deb`, all `cnt`, `image`, `edge`.
  - `inputReadOut`, `inputEdgeOut`, `inputReadValid`.
- **Reset mid-debounce:** any partial count is lost. After reset releases, an input held at 1 is accepted as a fresh 0→1 transition.

## Timing
- **Input to debounced.** Input stable from before edge E0 and differing from `deb`: `sync1` at E0, `sync2` at E1, `deb` flips at edge E(1+`DEBOUNCE_CYCLES`). Default: E5. With `DEBOUNCE_CYCLES=1`: E2.
- **Debounced to image.** Visible in `image` at the first `scanLatch` edge after the flip. A `scanLatch` at the same edge as the flip captures the old `deb`.
- **Read latency.** 1 cycle from `inputRd` sampled to valid outputs.
- **Reset values.** All outputs are 0 at the first edge with `reset = 1`.

## Test plan
- **Reset.** `reset` high for 2 cycles with `inputs = 8'hFF` → all outputs 0. After release, reads of addresses 0..7 return 0/0 with valid=1.
- **Debounce accept.** `DEBOUNCE_CYCLES=4`, `inputs[3]` 0→1 before E0 and held → `deb[3]` is 1 at E5, not at E4. Then `scanLatch` at E6 and read of addr 3 at E7 → `inputReadOut=1`, `inputEdgeOut=1` at E8.
- **Glitch reject.** `inputs[5]` high for exactly 3 cycles, then low → `deb[5]` stays 0. A later latch and read of addr 5 → 0/0.
- **Edge clear.** `inputs[3]` held 1 across two `scanLatch` pulses → after the second latch, read addr 3 gives `inputReadOut=1`, `inputEdgeOut=0`. Drop to 0 and latch → 0/0; the falling change sets no edge.
- **Simultaneous latch/read.** `image[0]=0` and `deb[0]=1`; assert `scanLatch` and `inputRd` (addr 0) at the same edge → read returns 0. Repeat the read on the next cycle → returns 1 with edge 1.
- **Out-of-range and reset mid-debounce.** `INPUT_NUMBER=6`, read addr 7 → 0/0 with valid=1. Assert `reset` 2 cycles into an input rise and hold the input → `deb` reaches 1 exactly `DEBOUNCE_CYCLES+2` edges after release.
